// File: rtl/player_input_rx_if.sv
// Bus bundle for player_input_rx: the serial line and player-count
// configuration in, decoded per-player state and frame strobes out.
interface player_input_rx_if;
    logic        serial_in;
    logic [1:0]  num_players;
    logic [23:0] player_buttons;
    logic [3:0]  player_active;
    logic        frame_valid;
    logic [1:0]  frame_player;
    logic        parity_err;
    logic        frame_err;

    // Driver side: supplies the line and configuration, observes results
    modport master (
        output serial_in,
        output num_players,
        input  player_buttons,
        input  player_active,
        input  frame_valid,
        input  frame_player,
        input  parity_err,
        input  frame_err
    );

    // Receiver side
    modport slave (
        input  serial_in,
        input  num_players,
        output player_buttons,
        output player_active,
        output frame_valid,
        output frame_player,
        output parity_err,
        output frame_err
    );
endinterface

// File: rtl/player_input_rx.sv
// Serial controller-frame receiver for the primary board.
// Decodes 8E1 frames {ID[1:0], carry, chop, up, down, left, right},
// keeps the latest state per remote player and drops a player whose
// link has been silent for TIMEOUT_CYCLES.
module player_input_rx #(
    parameter int CLKS_PER_BIT   = 217,
    parameter int TIMEOUT_CYCLES = 2500000
) (
    input  logic             clock,
    input  logic             reset,
    player_input_rx_if.slave bus
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } state_t;

    // Synchronizer and receive FSM
    logic          r_sync1;
    logic          r_sync2;
    logic          w_rx;
    state_t        r_state;
    state_t        w_next_state;
    logic [CW-1:0] r_clk_cnt;
    logic [2:0]    r_bit_cnt;
    logic [7:0]    r_shift;
    logic          r_parity_bit;

    // Decode strobes
    logic          w_half_tick;
    logic          w_bit_tick;
    logic          w_stop_sample;
    logic          w_parity_ok;
    logic          w_frame_good;
    logic          w_frame_err;
    logic          w_parity_err;
    logic [1:0]    w_id;
    logic          w_accept;

    // Registered outputs and per-player state
    logic             r_frame_valid;
    logic [1:0]       r_frame_player;
    logic             r_parity_err;
    logic             r_frame_err;
    logic [3:0][5:0]  r_buttons;
    logic [3:0]       r_active;
    logic [TW-1:0]    r_to_cnt [4];

    assign w_rx = r_sync2;

    // Two-flop synchronizer; idles high so reset does not look like a start bit
    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= bus.serial_in;
            r_sync2 <= r_sync1;
        end
    end

    // Sample-point strobes: half a bit into START, one full bit elsewhere
    assign w_half_tick = (r_state == START) && (r_clk_cnt == HALF_LAST);
    assign w_bit_tick  = ((r_state == DATA) || (r_state == PARITY) || (r_state == STOP))
                         && (r_clk_cnt == BIT_LAST);

    // FSM state register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            IDLE: begin
                if (!w_rx) begin
                    w_next_state = START;
                end
            end
            START: begin
                if (w_half_tick) begin
                    w_next_state = w_rx ? IDLE : DATA;
                end
            end
            DATA: begin
                if (w_bit_tick && (r_bit_cnt == 3'd7)) begin
                    w_next_state = PARITY;
                end
            end
            PARITY: begin
                if (w_bit_tick) begin
                    w_next_state = STOP;
                end
            end
            STOP: begin
                if (w_bit_tick) begin
                    w_next_state = w_rx ? IDLE : BREAK;
                end
            end
            BREAK: begin
                if (w_rx) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // FSM output decode: resolve the frame at the stop-bit sample
    always_comb begin
        w_stop_sample = (r_state == STOP) && w_bit_tick;
        w_parity_ok   = ~(^{r_shift, r_parity_bit});
        w_frame_err   = w_stop_sample && !w_rx;
        w_parity_err  = w_stop_sample && w_rx && !w_parity_ok;
        w_frame_good  = w_stop_sample && w_rx && w_parity_ok;
        w_id          = r_shift[7:6];
        w_accept      = w_frame_good && (w_id <= bus.num_players);
    end

    // Bit-period counter; cleared at every sample point and while waiting
    always_ff @(posedge clock) begin
        if (reset) begin
            r_clk_cnt <= '0;
        end else if (w_half_tick || w_bit_tick || (r_state == IDLE) || (r_state == BREAK)) begin
            r_clk_cnt <= '0;
        end else if (r_clk_cnt != BIT_LAST) begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
        end
    end

    // Data-bit index, cleared during START, saturating at the last bit
    always_ff @(posedge clock) begin
        if (reset) begin
            r_bit_cnt <= '0;
        end else if (r_state == START) begin
            r_bit_cnt <= '0;
        end else if ((r_state == DATA) && w_bit_tick && (r_bit_cnt != 3'd7)) begin
            r_bit_cnt <= r_bit_cnt + 3'd1;
        end
    end

    // Shift data in LSB first and capture the parity bit
    always_ff @(posedge clock) begin
        if (reset) begin
            r_shift      <= '0;
            r_parity_bit <= 1'b0;
        end else begin
            if ((r_state == DATA) && w_bit_tick) begin
                r_shift <= {w_rx, r_shift[7:1]};
            end
            if ((r_state == PARITY) && w_bit_tick) begin
                r_parity_bit <= w_rx;
            end
        end
    end

    // Frame strobes and last-accepted ID, registered one cycle after the stop sample
    always_ff @(posedge clock) begin
        if (reset) begin
            r_frame_valid  <= 1'b0;
            r_frame_player <= '0;
            r_parity_err   <= 1'b0;
            r_frame_err    <= 1'b0;
        end else begin
            r_frame_valid <= w_accept;
            r_parity_err  <= w_parity_err;
            r_frame_err   <= w_frame_err;
            if (w_accept) begin
                r_frame_player <= w_id;
            end
        end
    end

    // Per-player state and link timeout; a commit overrides an expiry in the same cycle
    always_ff @(posedge clock) begin
        if (reset) begin
            r_buttons <= '0;
            r_active  <= '0;
            for (int unsigned p = 0; p < 4; p++) begin
                r_to_cnt[p] <= '0;
            end
        end else begin
            for (int unsigned p = 0; p < 4; p++) begin
                if (w_accept && (w_id == 2'(p))) begin
                    r_buttons[p] <= r_shift[5:0];
                    r_active[p]  <= 1'b1;
                    r_to_cnt[p]  <= '0;
                end else if (r_active[p]) begin
                    if (r_to_cnt[p] == TO_LAST) begin
                        r_active[p]  <= 1'b0;
                        r_buttons[p] <= '0;
                    end else begin
                        r_to_cnt[p] <= r_to_cnt[p] + 1'b1;
                    end
                end
            end
        end
    end

    assign bus.player_buttons = r_buttons;
    assign bus.player_active  = r_active;
    assign bus.frame_valid    = r_frame_valid;
    assign bus.frame_player   = r_frame_player;
    assign bus.parity_err     = r_parity_err;
    assign bus.frame_err      = r_frame_err;

endmodule

// File: tb/tb_player_input_rx.sv
// Scoreboard bench for player_input_rx: stimulus pushes the expected
// strobe (with the state expected alongside it) and a negedge monitor
// pops and compares whenever the receiver pulses an output.
module tb_player_input_rx;

    localparam int CPB = 8;
    localparam int TO  = 1000;

    localparam int K_VALID  = 0;
    localparam int K_PARITY = 1;
    localparam int K_FRAME  = 2;

    logic clock = 1'b0;
    logic reset = 1'b1;

    player_input_rx_if bus ();

    player_input_rx #(
        .CLKS_PER_BIT  (CPB),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          kind;
        logic [1:0]  player;
        logic [23:0] buttons;
        logic [3:0]  active;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_valid_cyc = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    task automatic push(input int kind, input logic [1:0] p, input logic [23:0] b, input logic [3:0] a);
        exp_t e;
        e.kind = kind;
        e.player = p;
        e.buttons = b;
        e.active = a;
        q.push_back(e);
    endtask

    // Monitor: every strobe must match the head of the scoreboard
    always @(negedge clock) begin
        int k;
        exp_t e;
        if (!reset && (bus.frame_valid || bus.parity_err || bus.frame_err)) begin
            k = bus.frame_valid ? K_VALID : (bus.parity_err ? K_PARITY : K_FRAME);
            if (k == K_VALID) last_valid_cyc = cyc;
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event: got kind %0d expected none", k);
            end else begin
                e = q.pop_front();
                check("event_kind", k, e.kind);
                if (k == K_VALID && e.kind == K_VALID) begin
                    check("frame_player", bus.frame_player, e.player);
                    check("player_buttons", bus.player_buttons, e.buttons);
                    check("player_active", bus.player_active, e.active);
                end
            end
        end
    end

    task automatic send_bits(input logic [7:0] d, input logic par, input logic stop, input int nbits);
        logic [10:0] f;
        f = {stop, par, d, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            bus.serial_in = f[i];
            repeat (CPB) @(negedge clock);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par);
        send_bits(d, par, 1'b1, 11);
        bus.serial_in = 1'b1;
        repeat (4) @(negedge clock);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge clock);
        check("expected_event_seen", q.size(), 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.serial_in = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        repeat (4) @(negedge clock);
    endtask

    task automatic wait_clear0(output int gap);
        int n;
        n = 0;
        while (n < 1200 && bus.player_active[0]) begin
            @(negedge clock);
            n++;
        end
        gap = cyc - last_valid_cyc;
    endtask

    initial begin
        int t0;
        int gap;
        bus.serial_in   = 1'b1;
        bus.num_players = 2'd3;
        reset = 1'b1;
        repeat (4) @(negedge clock);
        check("rst_buttons", bus.player_buttons, 24'h0);
        check("rst_active", bus.player_active, 4'h0);
        check("rst_valid", bus.frame_valid, 1'b0);
        check("rst_player", bus.frame_player, 2'd0);
        check("rst_perr", bus.parity_err, 1'b0);
        check("rst_ferr", bus.frame_err, 1'b0);
        reset = 1'b0;
        repeat (5) @(negedge clock);

        // 0x5A: ID 1, buttons 011010, even parity 0
        push(K_VALID, 2'd1, 24'h000680, 4'b0010);
        send_frame(8'h5A, 1'b0);
        wait_drain();

        // 0xC1 with wrong parity: error only, state untouched
        push(K_PARITY, 2'd0, 24'h0, 4'h0);
        send_frame(8'hC1, 1'b0);
        wait_drain();
        check("perr_buttons_kept", bus.player_buttons, 24'h000680);
        check("perr_active_kept", bus.player_active, 4'b0010);
        check("perr_player_kept", bus.frame_player, 2'd1);

        // Bad stop bit, line held low, then a good frame
        do_reset();
        push(K_FRAME, 2'd0, 24'h0, 4'h0);
        send_bits(8'h00, 1'b0, 1'b0, 11);
        repeat (40) @(negedge clock);
        bus.serial_in = 1'b1;
        repeat (10) @(negedge clock);
        wait_drain();
        push(K_VALID, 2'd0, 24'h000003, 4'b0001);
        send_frame(8'h03, 1'b0);
        wait_drain();

        // ID above num_players is dropped silently
        do_reset();
        bus.num_players = 2'd1;
        send_frame(8'h85, 1'b1);
        repeat (20) @(negedge clock);
        check("discard_active", bus.player_active, 4'h0);
        check("discard_buttons", bus.player_buttons, 24'h0);
        push(K_VALID, 2'd1, 24'h000140, 4'b0010);
        send_frame(8'h45, 1'b1);
        wait_drain();

        // Timeout exactly TO cycles after the commit
        do_reset();
        bus.num_players = 2'd3;
        push(K_VALID, 2'd0, 24'h00002C, 4'b0001);
        send_frame(8'h2C, 1'b1);
        wait_drain();
        wait_clear0(gap);
        check("timeout_gap", gap, TO);
        check("timeout_buttons", bus.player_buttons, 24'h0);

        // Resend at cycle 900 restarts the window
        push(K_VALID, 2'd0, 24'h00002C, 4'b0001);
        send_frame(8'h2C, 1'b1);
        wait_drain();
        t0 = last_valid_cyc;
        while (cyc - t0 < 900) @(negedge clock);
        push(K_VALID, 2'd0, 24'h000015, 4'b0001);
        send_frame(8'h15, 1'b1);
        wait_drain();
        check("restart_commit_late", (last_valid_cyc - t0 > 900) ? 1 : 0, 1);
        wait_clear0(gap);
        check("restart_gap", gap, TO);
        check("restart_buttons", bus.player_buttons, 24'h0);

        // Two-cycle low glitch is rejected without error
        do_reset();
        bus.serial_in = 1'b0;
        repeat (2) @(negedge clock);
        bus.serial_in = 1'b1;
        repeat (30) @(negedge clock);
        check("glitch_active", bus.player_active, 4'h0);
        push(K_VALID, 2'd1, 24'h000FC0, 4'b0010);
        send_frame(8'h7F, 1'b1);
        wait_drain();

        // Reset in the middle of DATA, then a clean frame
        send_bits(8'hA5, 1'b0, 1'b1, 4);
        reset = 1'b1;
        bus.serial_in = 1'b1;
        repeat (3) @(negedge clock);
        check("midrst_buttons", bus.player_buttons, 24'h0);
        check("midrst_active", bus.player_active, 4'h0);
        check("midrst_player", bus.frame_player, 2'd0);
        reset = 1'b0;
        repeat (10) @(negedge clock);
        push(K_VALID, 2'd3, 24'h980000, 4'b1000);
        send_frame(8'hE6, 1'b1);
        wait_drain();

        repeat (20) @(negedge clock);
        check("scoreboard_empty", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
